// File: rtl/hamming74_pkg.sv
// Shared definitions for the Hamming(7,4) receive path: codeword bit
// positions, syndrome/codeword types, receiver FSM states and a parity helper.
package hamming74_pkg;

    localparam int P1_POS = 0;
    localparam int P2_POS = 1;
    localparam int A0_POS = 2;
    localparam int P3_POS = 3;
    localparam int A1_POS = 4;
    localparam int A2_POS = 5;
    localparam int A3_POS = 6;

    typedef logic [2:0] syndrome_t;
    typedef logic [6:0] codeword_t;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_RECV = 1'b1
    } rx_state_t;

    // Even parity over four bits; one syndrome bit is built from one call.
    function automatic logic parity4(input logic a, input logic b,
                                     input logic c, input logic d);
        return a ^ b ^ c ^ d;
    endfunction

endpackage

// File: rtl/hamming74_syndrome_correct.sv
// Combinational Hamming(7,4) syndrome computation and single-error
// correction. Kept separate so a parallel decoder can reuse it directly.
module hamming74_syndrome_correct
    import hamming74_pkg::*;
#(
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic [6:0] codeword,
    output logic [2:0] syndrome,
    output logic [3:0] data,
    output logic       corrected
);

    syndrome_t syn_s;
    codeword_t fixed_s;

    // Syndrome {s3,s2,s1}; odd-parity links invert every check.
    always_comb begin
        syn_s[0] = parity4(codeword[P1_POS], codeword[A0_POS],
                           codeword[A1_POS], codeword[A3_POS]) ^ ODD_PARITY;
        syn_s[1] = parity4(codeword[P2_POS], codeword[A0_POS],
                           codeword[A2_POS], codeword[A3_POS]) ^ ODD_PARITY;
        syn_s[2] = parity4(codeword[P3_POS], codeword[A1_POS],
                           codeword[A2_POS], codeword[A3_POS]) ^ ODD_PARITY;
    end

    // Flip the bit the syndrome points at (1-based position); zero means clean.
    always_comb begin
        fixed_s = codeword;
        case (syn_s)
            3'd1:    fixed_s[0] = ~codeword[0];
            3'd2:    fixed_s[1] = ~codeword[1];
            3'd3:    fixed_s[2] = ~codeword[2];
            3'd4:    fixed_s[3] = ~codeword[3];
            3'd5:    fixed_s[4] = ~codeword[4];
            3'd6:    fixed_s[5] = ~codeword[5];
            3'd7:    fixed_s[6] = ~codeword[6];
            default: fixed_s = codeword;
        endcase
    end

    assign syndrome  = syn_s;
    assign corrected = (syn_s != 3'd0);
    assign data      = {fixed_s[A3_POS], fixed_s[A2_POS],
                        fixed_s[A1_POS], fixed_s[A0_POS]};

endmodule

// File: rtl/hamming74_rx_decoder.sv
// Bit-serial Hamming(7,4) SEC receiver. Assembles codewords LSB first,
// corrects single errors and presents one nibble at a time on a
// valid/ready output register. Optional statistics counter (err_count)
// is built when HAMMING_RX_STATS_EN is defined.
module hamming74_rx_decoder
    import hamming74_pkg::*;
#(
    parameter int ODD_PARITY = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_bit,
    input  logic             rx_valid,
    input  logic             rx_sync,
    output logic [3:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_corrected,
    output logic [2:0]       out_syndrome,
    output logic             overflow,
    input  logic             clr_stats
`ifdef HAMMING_RX_STATS_EN
    ,
    output logic [CNT_W-1:0] err_count
`endif
);

    rx_state_t  state_r, state_nxt_s;
    logic [2:0] idx_r, idx_nxt_s;
    logic [5:0] sr_r, sr_nxt_s;
    logic       complete_s;

    codeword_t  codeword_s;
    syndrome_t  syn_s;
    logic [3:0] data_s;
    logic       corrected_s;

    logic       load_s;
    logic       drop_s;

    logic [3:0] out_data_r;
    logic       out_valid_r;
    logic       out_corrected_r;
    syndrome_t  out_syndrome_r;
    logic       overflow_r;

    // The final bit is used straight off the line so the word can be
    // decoded in the same cycle it completes.
    assign codeword_s = {rx_bit, sr_r};

    hamming74_syndrome_correct #(
        .ODD_PARITY (ODD_PARITY != 0)
    ) u_syndrome_correct (
        .codeword  (codeword_s),
        .syndrome  (syn_s),
        .data      (data_s),
        .corrected (corrected_s)
    );

    // Receiver state, bit index and partial-word shift register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_HUNT;
            idx_r   <= 3'd0;
            sr_r    <= 6'd0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            sr_r    <= sr_nxt_s;
        end
    end

    // Framing: sync always restarts a word; index 6 completes it.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        sr_nxt_s    = sr_r;
        complete_s  = 1'b0;
        case (state_r)
            ST_HUNT: begin
                if (rx_valid && rx_sync) begin
                    sr_nxt_s[0] = rx_bit;
                    idx_nxt_s   = 3'd1;
                    state_nxt_s = ST_RECV;
                end else begin
                    idx_nxt_s   = 3'd0;
                end
            end
            ST_RECV: begin
                if (rx_valid && rx_sync) begin
                    sr_nxt_s[0] = rx_bit;
                    idx_nxt_s   = 3'd1;
                end else if (rx_valid) begin
                    if (idx_r == 3'd6) begin
                        complete_s  = 1'b1;
                        idx_nxt_s   = 3'd0;
                        state_nxt_s = ST_HUNT;
                    end else begin
                        sr_nxt_s[idx_r] = rx_bit;
                        idx_nxt_s       = idx_r + 3'd1;
                    end
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            default: begin
                state_nxt_s = ST_HUNT;
                idx_nxt_s   = 3'd0;
            end
        endcase
    end

    // A completed word is accepted if the slot is empty or being emptied now.
    assign load_s = complete_s && (!out_valid_r || out_ready);
    assign drop_s = complete_s && out_valid_r && !out_ready;

    // One-entry output register plus sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_r      <= 4'd0;
            out_valid_r     <= 1'b0;
            out_corrected_r <= 1'b0;
            out_syndrome_r  <= 3'd0;
            overflow_r      <= 1'b0;
        end else begin
            if (load_s) begin
                out_data_r      <= data_s;
                out_corrected_r <= corrected_s;
                out_syndrome_r  <= syn_s;
                out_valid_r     <= 1'b1;
            end else if (out_valid_r && out_ready) begin
                out_valid_r     <= 1'b0;
            end
            if (clr_stats) begin
                overflow_r <= 1'b0;
            end else if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign out_data      = out_data_r;
    assign out_valid     = out_valid_r;
    assign out_corrected = out_corrected_r;
    assign out_syndrome  = out_syndrome_r;
    assign overflow      = overflow_r;

`ifdef HAMMING_RX_STATS_EN
    logic [CNT_W-1:0] err_cnt_r;

    // Saturating count of nonzero-syndrome words, dropped ones included.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_r <= {CNT_W{1'b0}};
        end else if (clr_stats) begin
            err_cnt_r <= {CNT_W{1'b0}};
        end else if (complete_s && corrected_s && (err_cnt_r != {CNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_count = err_cnt_r;
`endif

endmodule

// File: doc/hamming74_rx_decoder.md
# hamming74_rx_decoder

Bit-serial Hamming(7,4) single-error-correcting receiver. It is the receive-side counterpart of the team's Hamming(7,4) encoder. It assembles 7-bit codewords from a serial line, computes the 3-bit syndrome, corrects any single-bit error, and delivers the 4-bit data nibble over a valid/ready interface. It sits between the serial link front end and the downstream nibble consumer.

## Interface
Parameters:
- ODD_PARITY, default 0: 1 means the link uses inverted (odd) check bits, and every syndrome bit is XORed with 1.
- CNT_W, default 16: width of the corrected-error counter.

Ports:
- clk, input, 1: single clock. All logic is on the rising edge.
- rst_n, input, 1: reset. It is synchronous and active-low.
- rx_bit, input, 1: serial codeword bit, LSB (b[0]) first.
- rx_valid, input, 1: rx_bit is accepted on each edge where this is high.
- rx_sync, input, 1: qualified by rx_valid. Marks the accepted bit as b[0] of a new codeword.
- out_data, output, 4: corrected nibble {a3,a2,a1,a0}.
- out_valid, output, 1: out_data, out_corrected and out_syndrome are valid.
- out_ready, input, 1: the consumer accepts the output when out_valid && out_ready.
- out_corrected, output, 1: the delivered codeword had a nonzero syndrome.
- out_syndrome, output, 3: {s3,s2,s1}. A nonzero value is the 1-based bit position of the flipped bit.
- overflow, output, 1: sticky flag. A completed codeword was dropped.
- clr_stats, input, 1: synchronous clear of overflow and err_count.
- err_count, output, CNT_W: saturating count of nonzero-syndrome codewords. Present only under the macro.

## Operation
- Codeword layout: b0=p1, b1=p2, b2=a0, b3=p3, b4=a1, b5=a2, b6=a3.
- Check bits:
  - p1 = a0^a1^a3
  - p2 = a0^a2^a3
  - p3 = a1^a2^a3
- Syndrome:
  - s1 = b0^b2^b4^b6^ODD_PARITY
  - s2 = b1^b2^b5^b6^ODD_PARITY
  - s3 = b3^b4^b5^b6^ODD_PARITY
- FSM has two states:
  - HUNT: wait for rx_valid && rx_sync. That bit is stored as b0, bit index becomes 1, and the FSM goes to RECV.
  - RECV: each accepted bit is stored at the current index and the index increments.
  - On acceptance of index 6 the codeword is complete, and the FSM returns to HUNT.
  - rx_sync with rx_valid inside RECV aborts the partial codeword. That bit becomes b0 and the index becomes 1.
- Correction: for a nonzero syndrome, invert b[syndrome-1].
  - Syndromes 1, 2 and 4 (parity positions) leave the data unchanged but still set out_corrected.
  - Double errors are miscorrected. The block is SEC only, with no detection of double errors.
- Output register, one entry:
  - On completion with !out_valid, or with out_valid && out_ready in the same cycle: load the register and set out_valid.
  - On completion with out_valid && !out_ready: drop the new codeword, set overflow, and leave the held data untouched.
  - out_valid && out_ready with no completion: clear out_valid.
  - While out_valid=1, out_data, out_corrected and out_syndrome are stable.
- clr_stats clears overflow. If an overflow event occurs in the same cycle as clr_stats, clr_stats wins.

## Timing
- Reset values:
  - state = HUNT, bit index = 0
  - out_valid = 0, out_data = 0, out_corrected = 0, out_syndrome = 0
  - overflow = 0, err_count = 0
- Latency: out_valid rises on the edge that accepts b6 and is visible in the next cycle. Syndrome and correction are combinational on {rx_bit, shift register}.
- Back-to-back codewords are supported at 1 bit/cycle. The minimum spacing between out_valid pulses is 7 cycles.
- Reset asserted mid-codeword discards the partial word and any held output.

## Configuration
- HAMMING_RX_STATS_EN defined:
  - err_count port and counter are present.
  - The counter increments on every completed codeword with a nonzero syndrome, including dropped codewords.
  - It saturates at all ones.
  - clr_stats forces 0 and wins over a same-cycle increment.
- Not defined: no err_count port and no counter logic. clr_stats affects only overflow.

## Structure
- Package hamming74_pkg holds:
  - bit-position constants P1_POS=0, P2_POS=1, A0_POS=2, P3_POS=3, A1_POS=4, A2_POS=5, A3_POS=6
  - the syndrome typedef (3 bits) and codeword typedef (7 bits)
- One sub-module, hamming74_syndrome_correct: combinational. It takes the 7-bit codeword and ODD_PARITY, and returns the syndrome, the corrected nibble and the corrected flag. It is reusable by a future parallel decoder.

## Test plan
- Clean word: serial 7'h55 with ODD_PARITY=0 and rx_sync on the first bit -> out_data=4'b1011, out_corrected=0, out_syndrome=0. out_valid is visible one cycle after b6.
- Data error: serial 7'h45 (b4 flipped) -> out_data=4'b1011, out_syndrome=3'd5, out_corrected=1. err_count goes 0->1 under the macro.
- Parity error: serial 7'h54 (b0 flipped) -> out_data=4'b1011, out_syndrome=3'd1, out_corrected=1.
- Odd parity: ODD_PARITY=1, serial 7'h5E -> out_data=4'b1011, out_syndrome=0.
- Backpressure: out_ready=0 with two back-to-back words, 7'h55 then 7'h45 -> the first word is held, overflow=1, err_count=1. Then clr_stats=1 for one cycle -> overflow=0, err_count=0.
- Resync and reset:
  - rx_sync after 3 bits, then a full 7'h55 -> exactly one output, 4'b1011.
  - rst_n low for one cycle mid-word -> all outputs return to their reset values. The next word decodes correctly.
